// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one imem read per cycle, registers returned words for decode,
// absorbs a one-cycle stall with a single-entry skid buffer. Optional stop address via `FETCH_HALT_EN`.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] HALT_PC  = 32'd60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_flag,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_rd_en,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inp_instn,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        stall_flag_out,
  output logic        halted
);

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_STALL = 2'd1, ST_HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_STALL = 2'd1} state_t;
`endif

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_pending;
  logic [31:0] r_pend_pc;
  logic        r_skid_valid;
  logic [31:0] r_skid_instn;
  logic [31:0] r_skid_pc;
  logic [31:0] r_inp_instn;
  logic [31:0] r_if_pc;
  logic        r_if_valid;
  logic        r_stall_out;

  logic        w_halt_hit;
  logic        w_redirect;
  logic        w_issue;

`ifdef FETCH_HALT_EN
  logic        r_halted;

  assign w_halt_hit = (r_state == ST_RUN) && (r_pc == HALT_PC);
  // Once halted, only reset restarts fetching; redirects are ignored.
  assign w_redirect = branch_taken && (r_state != ST_HALT);
  assign halted     = r_halted;
`else
  logic        w_unused_halt_pc;

  assign w_halt_hit       = 1'b0;
  assign w_redirect       = branch_taken;
  assign halted           = 1'b0;
  assign w_unused_halt_pc = ^HALT_PC;
`endif

  // A full skid blocks issue so at most one word is ever outstanding beyond the output register.
  assign w_issue = reset && (r_state == ST_RUN) && !stall_flag && !r_skid_valid
                   && !branch_taken && !w_halt_hit;

  assign imem_rd_en     = w_issue;
  assign imem_addr      = r_pc[11:2];
  assign inp_instn      = r_inp_instn;
  assign if_pc          = r_if_pc;
  assign if_valid       = r_if_valid;
  assign stall_flag_out = r_stall_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_pending    <= 1'b0;
      r_pend_pc    <= 32'd0;
      r_skid_valid <= 1'b0;
      r_skid_instn <= 32'd0;
      r_skid_pc    <= 32'd0;
      r_inp_instn  <= 32'd0;
      r_if_pc      <= 32'd0;
      r_if_valid   <= 1'b0;
      r_stall_out  <= 1'b0;
`ifdef FETCH_HALT_EN
      r_halted     <= 1'b0;
`endif
    end else begin
      r_stall_out <= stall_flag;
      if (w_redirect) begin
        // Redirect wins over stall and over any word returning this cycle.
        r_pc         <= branch_target & ~32'd3;
        r_pending    <= 1'b0;
        r_skid_valid <= 1'b0;
        r_if_valid   <= 1'b0;
        r_state      <= ST_RUN;
      end else begin
        r_pending <= w_issue;
        if (w_issue) begin
          r_pend_pc <= r_pc;
          r_pc      <= r_pc + 32'd4;
        end

        if (r_pending) begin
          if (stall_flag) begin
            r_skid_valid <= 1'b1;
            r_skid_instn <= imem_rdata;
            r_skid_pc    <= r_pend_pc;
          end else begin
            r_inp_instn <= imem_rdata;
            r_if_pc     <= r_pend_pc;
            r_if_valid  <= 1'b1;
          end
        end else if (r_skid_valid && !stall_flag) begin
          r_inp_instn  <= r_skid_instn;
          r_if_pc      <= r_skid_pc;
          r_if_valid   <= 1'b1;
          r_skid_valid <= 1'b0;
        end else if (!stall_flag) begin
          r_if_valid <= 1'b0;
        end

        case (r_state)
          ST_RUN: begin
`ifdef FETCH_HALT_EN
            if (w_halt_hit) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else
`endif
            if (stall_flag) r_state <= ST_STALL;
          end
          ST_STALL: begin
            if (!stall_flag) r_state <= ST_RUN;
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized run against a
// queue-based transaction model. Halt checks are selected by FETCH_HALT_EN.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'd0;
  localparam logic [31:0] HALT_PC  = 32'd60;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_flag;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_rd_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inp_instn;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        stall_flag_out;
  logic        halted;

  logic [31:0] mem [0:1023];
  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(.RESET_PC(RESET_PC), .HALT_PC(HALT_PC)) dut (
    .clk(clk), .reset(reset), .stall_flag(stall_flag), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inp_instn(inp_instn), .if_pc(if_pc), .if_valid(if_valid),
    .stall_flag_out(stall_flag_out), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous memory; garbage on non-read cycles exposes a consumer sampling the wrong cycle.
  always @(posedge clk) imem_rdata <= imem_rd_en ? mem[imem_addr] : 32'hBADBAD00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_index_mem();
    for (int i = 0; i < 1024; i++) mem[i] = i;
  endtask

  task automatic do_reset();
    reset = 1'b0; stall_flag = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_pc;
  bit          m_stalled, m_halted, m_valid, m_sout;
  logic [31:0] m_opc, m_oinstn;
  logic [31:0] m_flight[$];
  logic [31:0] m_skid[$];

  function automatic void model_reset();
    m_pc = RESET_PC; m_stalled = 0; m_halted = 0; m_valid = 0; m_sout = 0;
    m_opc = 0; m_oinstn = 0;
    m_flight.delete(); m_skid.delete();
  endfunction

  function automatic bit model_issue(bit st, bit br);
    return !m_halted && !m_stalled && !st && (m_skid.size() == 0) && !br
           && !(HALT_EN && (m_pc == HALT_PC));
  endfunction

  function automatic void model_deliver(logic [31:0] a);
    m_valid = 1; m_opc = a; m_oinstn = mem[a[11:2]];
  endfunction

  function automatic void model_edge(bit st, bit br, logic [31:0] tgt);
    bit          iss;
    logic [31:0] pc0;
    iss = model_issue(st, br);
    pc0 = m_pc;
    m_sout = st;
    if (br && !m_halted) begin
      m_pc = tgt & ~32'd3;
      m_flight.delete(); m_skid.delete();
      m_valid = 0; m_stalled = 0;
      return;
    end
    if (m_flight.size() != 0) begin
      if (st) m_skid.push_back(m_flight.pop_front());
      else model_deliver(m_flight.pop_front());
    end else if (!st && m_skid.size() != 0) begin
      model_deliver(m_skid.pop_front());
    end else if (!st) begin
      m_valid = 0;
    end
    if (iss) begin
      m_flight.push_back(pc0);
      m_pc = pc0 + 32'd4;
    end
    if (!m_halted) begin
      if (HALT_EN && !m_stalled && pc0 == HALT_PC) m_halted = 1;
      else m_stalled = st;
    end
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; stall_flag = 1'b1; branch_taken = 1'b0; branch_target = 32'd0;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (inp_instn !== 32'd0) begin n_fail++; $display("FAIL reset_instn got=%h exp=0", inp_instn); end
    n_checks++; if (if_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    n_checks++; if (stall_flag_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall_out got=%b exp=0", stall_flag_out); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
    n_checks++; if (imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b exp=0", imem_rd_en); end
    $display("test_reset done, failures so far %0d", n_fail);
  endtask

  task automatic test_sequential();
    fill_index_mem();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (imem_rd_en !== 1'b1 || imem_addr !== k[9:0]) begin
        n_fail++; $display("FAIL seq_issue k=%0d got rd=%b addr=%0d exp rd=1 addr=%0d", k, imem_rd_en, imem_addr, k);
      end
      n_checks++;
      if (k >= 2) begin
        if (if_valid !== 1'b1 || inp_instn !== 32'(k - 2) || if_pc !== 32'((k - 2) * 4)) begin
          n_fail++; $display("FAIL seq_out k=%0d got v=%b i=%h pc=%h exp v=1 i=%h pc=%h",
                             k, if_valid, inp_instn, if_pc, 32'(k - 2), 32'((k - 2) * 4));
        end
      end else if (if_valid !== 1'b0) begin
        n_fail++; $display("FAIL seq_lat k=%0d got v=%b exp v=0", k, if_valid);
      end
      tick();
    end
    $display("test_sequential done, failures so far %0d", n_fail);
  endtask

  task automatic test_stall_skid();
    fill_index_mem();
    do_reset();
    tick(); tick(); tick();
    stall_flag = 1'b1; #1;
    n_checks++; if (imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL stall_rd got=%b exp=0", imem_rd_en); end
    tick();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'd4 || inp_instn !== 32'd1) begin
      n_fail++; $display("FAIL stall_hold got v=%b pc=%h i=%h exp v=1 pc=4 i=1", if_valid, if_pc, inp_instn);
    end
    n_checks++; if (stall_flag_out !== 1'b1) begin n_fail++; $display("FAIL stall_out got=%b exp=1", stall_flag_out); end
    stall_flag = 1'b0; #1;
    n_checks++; if (imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL stall_exit_rd got=%b exp=0", imem_rd_en); end
    tick();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'd8 || inp_instn !== 32'd2) begin
      n_fail++; $display("FAIL skid_out got v=%b pc=%h i=%h exp v=1 pc=8 i=2", if_valid, if_pc, inp_instn);
    end
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 10'd3) begin
      n_fail++; $display("FAIL stall_resume got rd=%b addr=%0d exp rd=1 addr=3", imem_rd_en, imem_addr);
    end
    tick();
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stall_bubble got=%b exp=0", if_valid); end
    tick();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'd12 || inp_instn !== 32'd3) begin
      n_fail++; $display("FAIL stall_next got v=%b pc=%h i=%h exp v=1 pc=c i=3", if_valid, if_pc, inp_instn);
    end
    $display("test_stall_skid done, failures so far %0d", n_fail);
  endtask

  task automatic test_branch();
    fill_index_mem();
    do_reset();
    tick(); tick();
    branch_taken = 1'b1; branch_target = 32'h43; #1;
    n_checks++; if (imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL br_rd got=%b exp=0", imem_rd_en); end
    tick();
    branch_taken = 1'b0; #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL br_drop got=%b exp=0", if_valid); end
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 10'd16) begin
      n_fail++; $display("FAIL br_target got rd=%b addr=%0d exp rd=1 addr=16", imem_rd_en, imem_addr);
    end
    tick();
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL br_gap got=%b exp=0", if_valid); end
    tick();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h40 || inp_instn !== 32'd16) begin
      n_fail++; $display("FAIL br_first got v=%b pc=%h i=%h exp v=1 pc=40 i=10", if_valid, if_pc, inp_instn);
    end
    $display("test_branch done, failures so far %0d", n_fail);
  endtask

  task automatic test_branch_stall();
    fill_index_mem();
    do_reset();
    tick(); tick(); tick();
    stall_flag = 1'b1;
    tick();
    branch_taken = 1'b1; branch_target = 32'h80; #1;
    n_checks++; if (imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL bs_rd got=%b exp=0", imem_rd_en); end
    tick();
    branch_taken = 1'b0; #1;
    n_checks++;
    if (if_valid !== 1'b0 || imem_rd_en !== 1'b0 || imem_addr !== 10'd32) begin
      n_fail++; $display("FAIL bs_redirect got v=%b rd=%b addr=%0d exp v=0 rd=0 addr=32", if_valid, imem_rd_en, imem_addr);
    end
    tick();
    stall_flag = 1'b0; #1;
    n_checks++; if (imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL bs_exit_rd got=%b exp=0", imem_rd_en); end
    tick();
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL bs_skid_cleared got=%b exp=0", if_valid); end
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 10'd32) begin
      n_fail++; $display("FAIL bs_issue got rd=%b addr=%0d exp rd=1 addr=32", imem_rd_en, imem_addr);
    end
    tick(); tick();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h80 || inp_instn !== 32'd32) begin
      n_fail++; $display("FAIL bs_first got v=%b pc=%h i=%h exp v=1 pc=80 i=20", if_valid, if_pc, inp_instn);
    end
    $display("test_branch_stall done, failures so far %0d", n_fail);
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    int          issues;
    logic [31:0] last_issue;
    logic [31:0] last_pc;
    issues = 0; last_issue = 32'hFFFF_FFFF; last_pc = 32'hFFFF_FFFF;
    fill_index_mem();
    do_reset();
    for (int k = 0; k < 22; k++) begin
      if (imem_rd_en) begin issues++; last_issue = {20'd0, imem_addr, 2'b00}; end
      if (if_valid) last_pc = if_pc;
      tick();
    end
    n_checks++; if (issues != 15) begin n_fail++; $display("FAIL halt_count got=%0d exp=15", issues); end
    n_checks++; if (last_issue !== 32'd56) begin n_fail++; $display("FAIL halt_last_issue got=%0d exp=56", last_issue); end
    n_checks++; if (last_pc !== 32'd56) begin n_fail++; $display("FAIL halt_last_pc got=%0d exp=56", last_pc); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag got=%b exp=1", halted); end
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    tick();
    n_checks++;
    if (imem_rd_en !== 1'b0 || imem_addr !== 10'd15 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_branch got rd=%b addr=%0d h=%b exp rd=0 addr=15 h=1", imem_rd_en, imem_addr, halted);
    end
    reset = 1'b0; #1;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset got=%b exp=0", halted); end
    tick();
    reset = 1'b1; #1;
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 10'd0) begin
      n_fail++; $display("FAIL halt_restart got rd=%b addr=%0d exp rd=1 addr=0", imem_rd_en, imem_addr);
    end
    $display("test_halt done, failures so far %0d", n_fail);
  endtask
`else
  task automatic test_no_halt();
    int issues;
    bit seen60;
    issues = 0; seen60 = 0;
    fill_index_mem();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (imem_rd_en) begin
        issues++;
        if (imem_addr == 10'd15) seen60 = 1;
      end
      tick();
    end
    n_checks++; if (issues != 20) begin n_fail++; $display("FAIL nohalt_count got=%0d exp=20", issues); end
    n_checks++; if (!seen60) begin n_fail++; $display("FAIL nohalt_60 got=0 exp=1"); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL nohalt_flag got=%b exp=0", halted); end
    $display("test_no_halt done, failures so far %0d", n_fail);
  endtask
`endif

  task automatic test_reset_skid();
    fill_index_mem();
    do_reset();
    tick(); tick(); tick();
    stall_flag = 1'b1;
    tick();
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (inp_instn !== 32'd0 || if_pc !== 32'd0 || if_valid !== 1'b0 || stall_flag_out !== 1'b0 || imem_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL rs_async got i=%h pc=%h v=%b so=%b rd=%b exp all 0",
                         inp_instn, if_pc, if_valid, stall_flag_out, imem_rd_en);
    end
    stall_flag = 1'b0;
    tick();
    reset = 1'b1; #1;
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 10'd0) begin
      n_fail++; $display("FAIL rs_restart got rd=%b addr=%0d exp rd=1 addr=0", imem_rd_en, imem_addr);
    end
    tick();
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rs_stale got v=%b pc=%h exp v=0", if_valid, if_pc); end
    tick();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'd0 || inp_instn !== 32'd0) begin
      n_fail++; $display("FAIL rs_first got v=%b pc=%h i=%h exp v=1 pc=0 i=0", if_valid, if_pc, inp_instn);
    end
    $display("test_reset_skid done, failures so far %0d", n_fail);
  endtask

  task automatic test_random();
    bit   exp_iss;
    int   errs_before;
    errs_before = n_fail;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 199) begin
        reset = 1'b0; stall_flag = 1'b0; branch_taken = 1'b0; #1;
        model_reset();
        n_checks++;
        if (if_valid !== 1'b0 || imem_rd_en !== 1'b0) begin
          n_fail++; $display("FAIL rnd_reset cyc=%0d got v=%b rd=%b exp 0 0", cyc, if_valid, imem_rd_en);
        end
        tick();
        reset = 1'b1;
      end
      stall_flag   = ($urandom_range(3) == 0);
      branch_taken = ($urandom_range(15) == 0);
      case ($urandom_range(7))
        0:       branch_target = $urandom_range(127);
        1:       branch_target = 32'hFFFF_FFF0 + $urandom_range(15);
        default: branch_target = $urandom;
      endcase
      #1;
      exp_iss = model_issue(stall_flag, branch_taken);
      n_checks++;
      if (imem_rd_en !== exp_iss || imem_addr !== m_pc[11:2]) begin
        n_fail++; $display("FAIL rnd_issue cyc=%0d got rd=%b addr=%0d exp rd=%b addr=%0d",
                           cyc, imem_rd_en, imem_addr, exp_iss, m_pc[11:2]);
      end
      tick();
      model_edge(stall_flag, branch_taken, branch_target);
      n_checks++;
      if (if_valid !== m_valid || (m_valid && (if_pc !== m_opc || inp_instn !== m_oinstn))) begin
        n_fail++; $display("FAIL rnd_out cyc=%0d got v=%b pc=%h i=%h exp v=%b pc=%h i=%h",
                           cyc, if_valid, if_pc, inp_instn, m_valid, m_opc, m_oinstn);
      end
      n_checks++;
      if (stall_flag_out !== m_sout || halted !== m_halted) begin
        n_fail++; $display("FAIL rnd_flags cyc=%0d got so=%b h=%b exp so=%b h=%b",
                           cyc, stall_flag_out, halted, m_sout, m_halted);
      end
    end
    $display("test_random done, %0d new failures", n_fail - errs_before);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_skid();
    test_branch();
    test_branch_stall();
`ifdef FETCH_HALT_EN
    test_halt();
`else
    test_no_halt();
`endif
    test_reset_skid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'd0: byte address of the first fetch after reset.
REQ-002 Parameter HALT_PC, default 32'd60: byte address at which fetching stops (FETCH_HALT_EN only).
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port stall_flag  input  1: decode back-pressure; 1 = do not accept a new instruction.
REQ-006 Port branch_taken  input  1: single-cycle redirect request.
REQ-007 Port branch_target  input  32: redirect byte address.
REQ-008 Port imem_rd_en  output  1: instruction-memory read strobe.
REQ-009 Port imem_addr  output  10: word index, always pc[11:2].
REQ-010 Port imem_rdata  input  32: memory read data, valid exactly one cycle after imem_rd_en.
REQ-011 Port inp_instn  output  32: registered instruction to decode.
REQ-012 Port if_pc  output  32: byte address of inp_instn.
REQ-013 Port if_valid  output  1: inp_instn/if_pc hold a live instruction.
REQ-014 Port stall_flag_out  output  1: stall_flag delayed one cycle.
REQ-015 Port halted  output  1: fetch stopped at HALT_PC.

Function
REQ-016 States RUN, STALL, HALT; internal pc (32 b), pending flag and pend_pc (request in flight), one-entry skid buffer (skid_valid, skid_instn, skid_pc).
REQ-017 Issue rule: imem_rd_en=1 iff state RUN, stall_flag=0, skid_valid=0, branch_taken=0; on issue pend_pc<=pc, pc<=pc+4 (wraps modulo 2^32).
REQ-018 Return: cycle after issue, if stall_flag=0, inp_instn<=imem_rdata, if_pc<=pend_pc, if_valid<=1; if stall_flag=1, data goes to skid, outputs hold.
REQ-019 Fetch-to-if_valid latency: 2 edges from the issuing edge's cycle; throughput one instruction per cycle without stall.
REQ-020 RUN->STALL when stall_flag=1; STALL->RUN when stall_flag=0; on that exit cycle skid (if valid) loads outputs and clears, no issue that cycle.
REQ-021 While stall_flag=1, inp_instn, if_pc, if_valid hold their values.
REQ-022 Cycle with stall_flag=0 and no return data and no skid: if_valid<=0.
REQ-023 branch_taken=1 (RUN or STALL): pc<=branch_target with bits [1:0] forced to 0, pending and skid cleared, if_valid<=0, no issue; next state RUN.
REQ-024 Branch has priority over stall and over a simultaneous return: returned data is discarded.
REQ-025 imem_addr beyond 1023 words wraps (pc[11:2] only); no error raised.
REQ-026 stall_flag_out<=stall_flag every edge.

Reset
REQ-027 reset=0 asynchronously forces: pc=RESET_PC, state RUN, pending=0, skid_valid=0, inp_instn=0, if_pc=0, if_valid=0, stall_flag_out=0, halted=0; imem_rd_en=0 while reset=0.
REQ-028 Reset mid-operation discards in-flight and skid data; first issue on first edge with reset=1, address RESET_PC.

Configuration
REQ-029 Macro FETCH_HALT_EN defined: in RUN with pc==HALT_PC no issue occurs, state->HALT, halted<=1; outstanding pending/skid data still delivered under normal stall rules.
REQ-030 In HALT branch_taken is ignored; only reset leaves HALT.
REQ-031 FETCH_HALT_EN undefined: no HALT state, halted tied 0, HALT_PC unused, fetch continues past any address.

Verification
REQ-032 Reset release, stall=0, mem[i]=i: imem_addr 0,1,2… consecutive cycles; if_valid rises 2 cycles later, inp_instn=0,1,2 with if_pc=0,4,8.
REQ-033 stall_flag=1 one cycle after issue of addr 8: word 2 captured in skid, outputs hold word 1; stall=0 -> word 2 output, then issue resumes at pc 12.
REQ-034 branch_taken=1, branch_target=32'h43 while request pending: returned word dropped, if_valid=0, next imem_addr=16 (pc=32'h40).
REQ-035 branch_taken and stall_flag both 1: redirect applied, no issue, skid cleared; next issue at target after stall drops.
REQ-036 FETCH_HALT_EN, HALT_PC=60: last issue at byte 56, halted=1 after, last if_pc=56; branch then ignored; reset=0 restarts at 0.
REQ-037 Assert reset=0 mid-stream with skid full: all outputs zero immediately (asynchronous), no stale instruction after release.
